shift_issue_stage: RTL and testbench
====================================

Name: shift_issue_stage

Overview:
- Registered, valid/ready-handshaked front-end for the ALU's 16-bit shift/rotate path.
- Accepts a shift request, drives an internal combinational log rotator (sub-module rotator16), and applies the fill mask for logical and arithmetic shifts.
- Registers the result and flags and hands them to the ALU result mux.
- 2-stage pipeline, one operation per cycle at full throughput.

Parameters:
- W, 16, data width; fixed at 16. Only value supported.
- SW, 4, shift-amount width; equals log2(W).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  stage can accept request
- in_op  input  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, others illegal
- in_amt  input  4  shift amount 0..15
- in_data  input  16  operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  16  shifted/rotated result
- out_carry  output  1  last bit shifted/rotated out
- out_zero  output  1  out_data == 0
- out_neg  output  1  out_data[15]
- out_err  output  1  illegal op code; out_data = operand unchanged

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low. Asserting rst_n = 0 immediately clears both stage valid bits, so out_valid = 0.
  - On reset, out_data, out_carry, out_zero, out_neg and out_err are all 0.
- Stage S1 (operand register):
  - Captures in_op, in_amt and in_data on an in_valid && in_ready handshake.
  - Sets s1_valid = 1 on capture.
- S1 to S2 advance:
  - Condition: s1_valid && (!s2_valid || out_ready).
  - On advance, S2 captures the computed result and flags.
  - S2 is the output register: out_valid = s2_valid.
- in_ready = !s1_valid || advance.
  - This is a combinational path from out_ready; it is accepted by design.
  - Simultaneous accept and advance is legal: S1 reloads in the same cycle.
- Latency and throughput:
  - The result appears on out_* on the 2nd rising edge after acceptance, given out_ready held high.
  - Sustained throughput is 1 op/cycle.
- Backpressure and drop rules:
  - While out_valid && !out_ready, all out_* hold stable.
  - At most 2 requests are in flight; in_ready falls when both stages are full.
  - No request is ever dropped or duplicated.
- Compute, combinational from S1:
  - ROL/SLL drive the rotator left (lr = 1); ROR/SRL/SRA drive it right (lr = 0). Rotation amount = in_amt.
  - SLL: zero the low n result bits.
  - SRL: zero the high n result bits.
  - SRA: replace the high n result bits with operand[15].
  - ROL/ROR: no masking.
  - amt = 0: result = operand for every op.
- Carry:
  - Left ops (ROL, SLL), n > 0: operand[16-n].
  - Right ops (ROR, SRL, SRA), n > 0: operand[n-1].
  - n = 0: carry = 0.
- Zero and negative flags: out_zero and out_neg are computed from the final result.
- Illegal op (101, 110, 111): out_data = operand, carry = 0, out_err = 1, flags computed normally. Illegal ops go through the handshake like any other op.
- Reset mid-operation: in-flight ops are discarded, not replayed. in_ready = 1 in the first cycle after deassertion.

Decomposition:
- Shared package (alu_pkg) holds:
  - op code constants: OP_ROL, OP_ROR, OP_SLL, OP_SRL, OP_SRA
  - the 3-bit op typedef
  - constants W = 16 and SW = 4
- One sub-module, rotator16 (combinational):
  - Inputs: shift[3:0], lr (1 = left), in[15:0]. Output: out[15:0].
  - Structure: four conditional stages of 1, 2, 4 and 8.
- This block contains the handshake, pipeline registers, fill mask and flag logic.

Test Plan:
- ROL 0x8001 amt 1, out_ready = 1 -> 2 cycles later out_data = 0x0003, carry 1, zero 0, neg 0.
- SRA 0x8000 amt 4 -> 0xF800, carry 0, neg 1. SRL 0x00F1 amt 4 -> 0x000F, carry 0. SLL 0x1234 amt 4 -> 0x2340, carry 1.
- SLL 0x8000 amt 1 -> 0x0000, zero 1, carry 1. ROR 0xA5A5 amt 0 -> 0xA5A5, carry 0. Op 111 on 0x1234 -> 0x1234, err 1.
- Back-to-back stream of 8 ops with out_ready = 1 -> in_ready stays 1, one result per cycle, results in order.
- Backpressure: hold out_ready = 0 and offer 3 requests -> 2 accepted, then in_ready = 0 with out_* stable. Raise out_ready -> all 3 results emerge in order, none lost.
- Pull rst_n low with 2 ops in flight mid-cycle -> out_valid drops immediately, out_* = 0. After release, in_ready = 1 and the stale results never appear.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU shared types and constants.
// Shift/rotate op codes and widths.
package alu_pkg;

  localparam int W  = 16;
  localparam int SW = 4;

  typedef logic [2:0] op_t;

  localparam op_t OP_ROL = 3'b000;
  localparam op_t OP_ROR = 3'b001;
  localparam op_t OP_SLL = 3'b010;
  localparam op_t OP_SRL = 3'b011;
  localparam op_t OP_SRA = 3'b100;

endpackage

// File: rtl/shift_issue_stage_rotator16.sv
// 16-bit combinational log rotator.
// Four conditional stages of 1, 2, 4, 8.
module rotator16
  import alu_pkg::*;
(
  input  logic [SW-1:0] shift,
  input  logic          lr,
  input  logic [W-1:0]  in,
  output logic [W-1:0]  out
);

  logic [W-1:0] s0;
  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;

  // Each stage rotates by its power of two when enabled.
  always_comb begin
    s0 = in;
    if (shift[0])
      s0 = lr ? {in[14:0], in[15]}
              : {in[0], in[15:1]};
    s1 = s0;
    if (shift[1])
      s1 = lr ? {s0[13:0], s0[15:14]}
              : {s0[1:0], s0[15:2]};
    s2 = s1;
    if (shift[2])
      s2 = lr ? {s1[11:0], s1[15:12]}
              : {s1[3:0], s1[15:4]};
    s3 = s2;
    if (shift[3])
      s3 = lr ? {s2[7:0], s2[15:8]}
              : {s2[7:0], s2[15:8]};
    out = s3;
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift/rotate issue stage: operand reg,
// rotator + fill mask, result/flag reg.
module shift_issue_stage
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [SW-1:0] in_amt,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_carry,
  output logic          out_zero,
  output logic          out_neg,
  output logic          out_err
);

  logic          s1_valid_q, s1_valid_d;
  op_t           s1_op_q, s1_op_d;
  logic [SW-1:0] s1_amt_q, s1_amt_d;
  logic [W-1:0]  s1_data_q, s1_data_d;

  logic          s2_valid_q, s2_valid_d;
  logic [W-1:0]  s2_data_q, s2_data_d;
  logic          s2_carry_q, s2_carry_d;
  logic          s2_zero_q, s2_zero_d;
  logic          s2_neg_q, s2_neg_d;
  logic          s2_err_q, s2_err_d;

  logic          advance;
  logic          accept;
  logic          lr;
  logic [W-1:0]  rot;
  logic [W-1:0]  lo_m;
  logic [W-1:0]  hi_m;
  logic [W-1:0]  res;
  logic          carry;
  logic          err;
  logic [SW-1:0] l_idx;
  logic [SW-1:0] r_idx;

  rotator16 u_rot (
    .shift (s1_amt_q),
    .lr    (lr),
    .in    (s1_data_q),
    .out   (rot)
  );

  // Handshake: S1 frees when it advances into S2.
  always_comb begin
    advance  = s1_valid_q &&
               (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || advance;
    accept   = in_valid && in_ready;
  end

  // Fill mask, carry and error from S1.
  always_comb begin
    lr    = (s1_op_q == OP_ROL) ||
            (s1_op_q == OP_SLL);
    lo_m  = ~({W{1'b1}} << s1_amt_q);
    hi_m  = ~({W{1'b1}} >> s1_amt_q);
    l_idx = 4'd0 - s1_amt_q;
    r_idx = s1_amt_q - 4'd1;
    res   = rot;
    carry = 1'b0;
    err   = 1'b0;
    if (s1_amt_q != '0)
      carry = lr ? s1_data_q[l_idx]
                 : s1_data_q[r_idx];
    unique case (1'b1)
      (s1_op_q == OP_ROL),
      (s1_op_q == OP_ROR): res = rot;
      (s1_op_q == OP_SLL): res = rot & ~lo_m;
      (s1_op_q == OP_SRL): res = rot & ~hi_m;
      (s1_op_q == OP_SRA):
        res = s1_data_q[15] ? (rot | hi_m)
                            : (rot & ~hi_m);
      default: begin
        res   = s1_data_q;
        carry = 1'b0;
        err   = 1'b1;
      end
    endcase
  end

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_amt_d   = s1_amt_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_carry_d = s2_carry_q;
    s2_zero_d  = s2_zero_q;
    s2_neg_d   = s2_neg_q;
    s2_err_d   = s2_err_q;
    if (advance)
      s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_amt_d   = in_amt;
      s1_data_d  = in_data;
    end
    if (out_ready)
      s2_valid_d = 1'b0;
    if (advance) begin
      s2_valid_d = 1'b1;
      s2_data_d  = res;
      s2_carry_d = carry;
      s2_zero_d  = (res == '0);
      s2_neg_d   = res[15];
      s2_err_d   = err;
    end
  end

  // Pipeline registers, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ROL;
      s1_amt_q   <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_carry_q <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_amt_q   <= s1_amt_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_carry_q <= s2_carry_d;
      s2_zero_q  <= s2_zero_d;
      s2_neg_q   <= s2_neg_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_carry = s2_carry_q;
  assign out_zero  = s2_zero_q;
  assign out_neg   = s2_neg_q;
  assign out_err   = s2_err_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage.
// Hand-computed vectors, immediate asserts.
module tb_shift_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_amt;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_carry;
  logic        out_zero;
  logic        out_neg;
  logic        out_err;

  int n_pass;
  int n_tot;

  shift_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated op: accept, wait 2 edges, check all flags.
  task automatic one(input string tag,
                     input logic [2:0] op,
                     input logic [3:0] amt,
                     input logic [15:0] d,
                     input logic [15:0] ed,
                     input logic ec,
                     input logic ez,
                     input logic en,
                     input logic ee);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_amt    = amt;
    in_data   = d;
    #1;
    chk({tag, ".rdy"}, 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, ".v1"}, 16'(out_valid), 16'd0);
    tick();
    chk({tag, ".vld"}, 16'(out_valid), 16'd1);
    chk({tag, ".dat"}, out_data, ed);
    chk({tag, ".flg"},
        16'({out_carry, out_zero, out_neg, out_err}),
        16'({ec, ez, en, ee}));
    tick();
  endtask

  initial begin
    int got;
    int first;
    int last;
    int acc;
    logic [15:0] exq[$];

    n_pass    = 0;
    n_tot     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'b000;
    in_amt    = 4'd0;
    in_data   = 16'h0;
    out_ready = 1'b0;

    #12;
    chk("rst.vld", 16'(out_valid), 16'd0);
    chk("rst.dat", out_data, 16'h0);
    chk("rst.flg",
        16'({out_carry, out_zero, out_neg, out_err}),
        16'h0);
    rst_n = 1'b1;
    tick();
    chk("rst.rdy", 16'(in_ready), 16'd1);

    one("rol", 3'b000, 4'd1, 16'h8001,
        16'h0003, 1, 0, 0, 0);
    one("sra", 3'b100, 4'd4, 16'h8000,
        16'hF800, 0, 0, 1, 0);
    one("srl", 3'b011, 4'd4, 16'h00F1,
        16'h000F, 0, 0, 0, 0);
    one("sll", 3'b010, 4'd4, 16'h1234,
        16'h2340, 1, 0, 0, 0);
    one("sllz", 3'b010, 4'd1, 16'h8000,
        16'h0000, 1, 1, 0, 0);
    one("ror0", 3'b001, 4'd0, 16'hA5A5,
        16'hA5A5, 0, 0, 1, 0);
    one("ill", 3'b111, 4'd3, 16'h1234,
        16'h1234, 0, 0, 0, 1);
    one("ror1", 3'b001, 4'd1, 16'h0001,
        16'h8000, 1, 0, 1, 0);
    one("sra15", 3'b100, 4'd15, 16'h7FF0,
        16'h0000, 1, 1, 0, 0);
    one("srl15", 3'b011, 4'd15, 16'hFFFF,
        16'h0001, 1, 0, 0, 0);
    one("rol8", 3'b000, 4'd8, 16'h1234,
        16'h3412, 0, 0, 0, 0);

    // Back-to-back stream of 8 ROLs of 1.
    out_ready = 1'b1;
    got   = 0;
    first = -1;
    last  = -1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      in_op    = 3'b000;
      in_amt   = 4'(c);
      in_data  = 16'h0001;
      #1;
      if (c < 8)
        chk("strm.rdy", 16'(in_ready), 16'd1);
      if (out_valid) begin
        chk("strm.dat", out_data,
            16'(16'h1 << got));
        if (first < 0) first = c;
        last = c;
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("strm.cnt", 16'(got), 16'd8);
    chk("strm.span", 16'(last - first), 16'd7);

    // Backpressure: 3 offered, 2 accepted.
    out_ready = 1'b0;
    exq = '{16'h1111, 16'h2222, 16'h3333};
    acc = 0;
    in_op  = 3'b000;
    in_amt = 4'd0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = exq[acc];
      #1;
      if (in_ready) acc++;
      tick();
    end
    chk("bp.acc", 16'(acc), 16'd2);
    chk("bp.rdy", 16'(in_ready), 16'd0);
    chk("bp.vld", 16'(out_valid), 16'd1);
    chk("bp.hold", out_data, 16'h1111);
    tick();
    chk("bp.hold2", out_data, 16'h1111);
    chk("bp.rdy2", 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (acc < 3);
      in_data  = exq[2];
      #1;
      if (in_valid && in_ready) acc++;
      if (out_valid && got < 3) begin
        chk("bp.dat", out_data, exq[got]);
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("bp.cnt", 16'(got), 16'd3);
    chk("bp.acc3", 16'(acc), 16'd3);

    // Reset with two ops in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'b111;
    in_amt    = 4'd2;
    in_data   = 16'h1234;
    tick();
    in_op   = 3'b000;
    in_data = 16'h00FF;
    tick();
    in_valid = 1'b0;
    chk("rm.pre", 16'(out_err), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm.vld", 16'(out_valid), 16'd0);
    chk("rm.dat", out_data, 16'h0);
    chk("rm.err", 16'(out_err), 16'd0);
    out_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    tick();
    chk("rm.rdy", 16'(in_ready), 16'd1);
    got = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) got++;
      tick();
    end
    chk("rm.stale", 16'(got), 16'd0);

    one("post", 3'b010, 4'd15, 16'h0003,
        16'h8000, 1, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
